// File: rtl/reg_bank_pkg.sv
// Shared constants for the 16-entry x 16-bit register bank.
// Contents:
//   DW       data width per register
//   AW       address width
//   N_REGS   number of entries (2**AW)
//   RST_VAL  value loaded by reset and by the bulk clear sweep
//   S_IDLE / S_CLEAR  state encoding of the clear sequencer
package reg_bank_pkg;

  localparam int DW     = 16;
  localparam int AW     = 4;
  localparam int N_REGS = 1 << AW;

  localparam logic [DW-1:0] RST_VAL = 16'h0000;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  // Last sweep index; the clear leaves CLEAR when the counter sits here.
  localparam logic [AW-1:0] CNT_LAST = 4'hF;

endpackage

// File: rtl/dec_4to16.sv
// 4-to-16 one-hot decoder with enable.
// Ports:
//   addr    in   4    index to decode
//   en      in   1    when low the output is all zeros
//   onehot  out  16   bit addr set when en is high, otherwise zero
// The output is strictly one-hot or all-zero, so at most one register
// in the bank can be selected by any single instance.
module dec_4to16 (
  input  logic [3:0]  addr,
  input  logic        en,
  output logic [15:0] onehot
);

  // Gated one-hot decode of addr.
  always_comb begin
    onehot = 16'h0000;
    if (en) begin
      onehot[addr] = 1'b1;
    end else begin
      onehot = 16'h0000;
    end
  end

endmodule

// File: rtl/reg_bank_16x16_wr.sv
// Write side of the 16-entry x 16-bit register bank.
// Accepts one write per cycle through a valid/ready handshake, runs a
// sequenced bulk clear (one entry per cycle, entry 0 first) and presents
// every register flat to the datapath read mux.
// Ports:
//   clk       in   1        system clock, rising edge
//   rst       in   1        asynchronous, active-high reset
//   wr_valid  in   1        write request
//   wr_ready  out  1        bank can accept a write this cycle (idle)
//   wr_addr   in   AW       target register index
//   wr_data   in   DW       write data
//   clr_req   in   1        one-cycle pulse starting the bulk clear
//   clr_busy  out  1        bulk clear in progress
//   q_flat    out  DW*16    register k at q_flat[DW*k+DW-1 : DW*k]
//   written   out  16       bit k set when register k was written since last reset/clear
module reg_bank_16x16_wr
  import reg_bank_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [AW-1:0]        wr_addr,
  input  logic [DW-1:0]        wr_data,
  input  logic                 clr_req,
  output logic                 clr_busy,
  output logic [DW*N_REGS-1:0] q_flat,
  output logic [N_REGS-1:0]    written
);

  logic [0:0]          state_r;
  logic [0:0]          state_nxt_s;
  logic [AW-1:0]       clr_cnt_r;
  logic [AW-1:0]       clr_cnt_nxt_s;
  logic [DW-1:0]       regs_r [N_REGS];
  logic [N_REGS-1:0]   written_r;
  logic                wr_accept_s;
  logic                clr_active_s;
  logic [N_REGS-1:0]   wr_en_s;
  logic [N_REGS-1:0]   clr_en_s;

  // Handshake and status are pure decodes of the state register, so
  // wr_ready never depends on wr_valid.
  assign wr_ready     = (state_r == S_IDLE);
  assign clr_busy     = (state_r == S_CLEAR);
  assign clr_active_s = (state_r == S_CLEAR);
  assign wr_accept_s  = wr_valid & wr_ready;

  // Write decoder: only enabled on an accepted write, so wr_addr is don't-care otherwise.
  dec_4to16 u_dec_wr (
    .addr   (wr_addr),
    .en     (wr_accept_s),
    .onehot (wr_en_s)
  );

  // Sweep decoder: selects the entry being cleared this cycle.
  dec_4to16 u_dec_clr (
    .addr   (clr_cnt_r),
    .en     (clr_active_s),
    .onehot (clr_en_s)
  );

  // Clear sequencer next-state: clr_req is only looked at in IDLE, so a
  // request during CLEAR neither restarts nor extends the sweep.
  always_comb begin
    state_nxt_s   = state_r;
    clr_cnt_nxt_s = clr_cnt_r;
    case (state_r)
      S_IDLE: begin
        if (clr_req) begin
          state_nxt_s = S_CLEAR;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_CLEAR: begin
        // Counter wraps 15->0 on the exit edge, leaving it ready for the next sweep.
        clr_cnt_nxt_s = clr_cnt_r + 4'd1;
        if (clr_cnt_r == CNT_LAST) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_CLEAR;
        end
      end
      default: begin
        state_nxt_s   = S_IDLE;
        clr_cnt_nxt_s = 4'd0;
      end
    endcase
  end

  // Sequencer state and sweep counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_IDLE;
      clr_cnt_r <= 4'd0;
    end else begin
      state_r   <= state_nxt_s;
      clr_cnt_r <= clr_cnt_nxt_s;
    end
  end

  // Register array and written mask. Writes are only accepted in IDLE and
  // the sweep only runs in CLEAR, so the two enables never hit the same
  // entry on the same edge; the write branch still takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_REGS; k++) begin
        regs_r[k] <= RST_VAL;
      end
      written_r <= 16'h0000;
    end else begin
      for (int k = 0; k < N_REGS; k++) begin
        if (wr_en_s[k]) begin
          regs_r[k]    <= wr_data;
          written_r[k] <= 1'b1;
        end else if (clr_en_s[k]) begin
          regs_r[k]    <= RST_VAL;
          written_r[k] <= 1'b0;
        end else begin
          regs_r[k]    <= regs_r[k];
          written_r[k] <= written_r[k];
        end
      end
    end
  end

  assign written = written_r;

  // Pack the register array onto the flat read bus, entry 0 in the LSBs.
  always_comb begin
    q_flat = {(DW*N_REGS){1'b0}};
    for (int k = 0; k < N_REGS; k++) begin
      q_flat[DW*k +: DW] = regs_r[k];
    end
  end

endmodule

// File: tb/tb_reg_bank_16x16_wr.sv
module tb_reg_bank_16x16_wr;

  logic         clk;
  logic         rst;
  logic         wr_valid;
  logic         wr_ready;
  logic [3:0]   wr_addr;
  logic [15:0]  wr_data;
  logic         clr_req;
  logic         clr_busy;
  logic [255:0] q_flat;
  logic [15:0]  written;

  reg_bank_16x16_wr dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .q_flat   (q_flat),
    .written  (written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
    logic [15:0] exp_written;
  } vec_t;

  int     n_cmp;
  int     n_mis;
  wr_t    sb[$];
  vec_t   vecs[18];
  logic [15:0] mdl [16];
  logic [15:0] mdl_wr;

  function automatic logic [255:0] mdl_flat();
    logic [255:0] f;
    f = 256'd0;
    for (int k = 0; k < 16; k++) f[16*k +: 16] = mdl[k];
    return f;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a write and push its expected effect to the scoreboard.
  task automatic drive_write(input logic [3:0] a, input logic [15:0] d);
    wr_t e;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    e.addr   = a;
    e.data   = d;
    sb.push_back(e);
  endtask

  // Pop the oldest expected write after its accept edge and compare the entry.
  task automatic check_write(input string name);
    wr_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_mis++;
      $display("FAIL %s: scoreboard empty got %0d want 1", name, sb.size());
    end else begin
      n_cmp--;
      e = sb.pop_front();
      mdl[e.addr] = e.data;
      mdl_wr[e.addr] = 1'b1;
      chk(name, {240'd0, q_flat[16*e.addr +: 16]}, {240'd0, e.data});
    end
  endtask

  task automatic check_all(input string name);
    chk({name, "_q"}, q_flat, mdl_flat());
    chk({name, "_written"}, {240'd0, written}, {240'd0, mdl_wr});
  endtask

  task automatic check_status(input string name, input logic exp_busy);
    chk({name, "_busy"}, {255'd0, clr_busy}, {255'd0, exp_busy});
    chk({name, "_ready"}, {255'd0, wr_ready}, {255'd0, ~exp_busy});
  endtask

  initial begin
    logic [31:0] tmp;
    n_cmp    = 0;
    n_mis    = 0;
    rst      = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = 4'd0;
    wr_data  = 16'h0000;
    clr_req  = 1'b0;
    for (int k = 0; k < 16; k++) mdl[k] = 16'h0000;
    mdl_wr = 16'h0000;

    // Vector table: two single writes, then a back-to-back fill.
    vecs[0] = '{4'd3,  16'hBEEF, 16'h0008};
    vecs[1] = '{4'd15, 16'h1234, 16'h8008};
    for (int k = 0; k < 16; k++) begin
      tmp = (32'd2 << k) - 32'd1;
      vecs[2+k].addr = 4'(k);
      vecs[2+k].data = 16'hA000 + 16'(k);
      vecs[2+k].exp_written = 16'h8008 | tmp[15:0];
    end

    // Asynchronous reset asserted mid-cycle, checked before any clock edge.
    #2 rst = 1'b1;
    #1;
    check_all("async_rst");
    check_status("async_rst", 1'b0);
    step();
    step();
    rst = 1'b0;
    step();
    check_all("post_rst");

    // Single writes with idle cycles between.
    for (int i = 0; i < 2; i++) begin
      drive_write(vecs[i].addr, vecs[i].data);
      step();
      wr_valid = 1'b0;
      check_write("single_wr");
      chk("single_written", {240'd0, written}, {240'd0, vecs[i].exp_written});
      step();
    end
    check_all("single_all");

    // Back-to-back fill, wr_ready must stay high.
    for (int i = 2; i < 18; i++) begin
      drive_write(vecs[i].addr, vecs[i].data);
      step();
      check_write("b2b_wr");
      chk("b2b_written", {240'd0, written}, {240'd0, vecs[i].exp_written});
      chk("b2b_ready", {255'd0, wr_ready}, 256'd1);
    end
    wr_valid = 1'b0;
    check_all("fill_all");

    // Bulk clear with a write held pending throughout.
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    check_status("clr_c0", 1'b1);
    wr_valid = 1'b1;
    wr_addr  = 4'd7;
    wr_data  = 16'h5555;
    for (int c = 1; c <= 16; c++) begin
      if (c == 16) drive_write(4'd7, 16'h5555);
      step();
      mdl[c-1] = 16'h0000;
      mdl_wr[c-1] = 1'b0;
      check_all("clr_sweep");
      check_status("clr_sweep", c < 16);
    end
    step();
    wr_valid = 1'b0;
    check_write("held_wr");
    check_all("held_all");

    // Same-edge write + clear, second clr_req at clear cycle 5.
    drive_write(4'd9, 16'h7777);
    clr_req = 1'b1;
    step();
    wr_valid = 1'b0;
    clr_req  = 1'b0;
    check_write("same_edge_wr");
    check_status("same_c0", 1'b1);
    for (int c = 1; c <= 16; c++) begin
      if (c == 5) clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      mdl[c-1] = 16'h0000;
      mdl_wr[c-1] = 1'b0;
      chk("same_e9", {240'd0, q_flat[159:144]}, {240'd0, (c < 10) ? 16'h7777 : 16'h0000});
      check_all("same_sweep");
      check_status("same_sweep", c < 16);
    end
    step();
    check_status("same_noext", 1'b0);

    // Refill upper entries, then reset in the middle of a clear.
    for (int k = 10; k < 16; k++) begin
      drive_write(4'(k), 16'hC000 + 16'(k));
      step();
      check_write("refill_wr");
    end
    wr_valid = 1'b0;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      step();
      mdl[c-1] = 16'h0000;
      mdl_wr[c-1] = 1'b0;
    end
    check_all("pre_rst_clr");
    check_status("pre_rst_clr", 1'b1);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 16; k++) mdl[k] = 16'h0000;
    mdl_wr = 16'h0000;
    check_all("mid_clr_rst");
    check_status("mid_clr_rst", 1'b0);
    step();
    rst = 1'b0;
    drive_write(4'd2, 16'h00FF);
    step();
    wr_valid = 1'b0;
    check_write("post_rst_wr");
    check_all("post_rst_all");
    check_status("post_rst_all", 1'b0);

    chk("sb_drained", {224'd0, 32'(sb.size())}, 256'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
